fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16, instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 8, instruction memory address width.
REQ-003 Parameter DRAIN_CYCLES, default 4, bubble cycles needed to empty ID/EX/MEM/WB on stop.
REQ-004 clk  in  1  single clock, all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start, stop  in  1 each  run request / halt request.
REQ-007 load_valid_i  in  1; load_last_i  in  1; load_addr_i  in  ADDR_WIDTH; load_data_i  in  DATA_WIDTH  program-load write stream.
REQ-008 load_ready_o  out  1  loader handshake ready.
REQ-009 if_addr_i  in  ADDR_WIDTH  fetch PC from IF stage.
REQ-010 im_addr_o  out  ADDR_WIDTH; im_rd_o, im_wr_o  out  1; im_wdata_o  out  DATA_WIDTH  shared IM port.
REQ-011 load_use_i, branch_taken_i, jump_i  in  1 each  hazard and redirect indications from ID.
REQ-012 stallPC_o, stallIF_ID_o, flushIF_ID_o, flushID_EX_o  out  1 each  pipeline controls.
REQ-013 run_o  out  1; state_o  out  3; load_cnt_o  out  ADDR_WIDTH+1; stall_cnt_o  out  16  status.

Function
REQ-014 FSM states IDLE=0, LOAD=1, RUN=2, DRAIN=3, HALT=4; state_o = current state; run_o = 1 only in RUN.
REQ-015 IDLE/HALT: load_valid_i -> LOAD (priority); else start -> RUN; else hold.
REQ-016 LOAD: load_ready_o=1; write accepted when load_valid_i && load_ready_o; accepted write with load_last_i -> IDLE next cycle; stop -> IDLE, no write that cycle.
REQ-017 LOAD IM port: im_addr_o=load_addr_i, im_wdata_o=load_data_i, im_wr_o=accept, im_rd_o=0; write lands same cycle (zero latency).
REQ-018 load_cnt_o cleared on LOAD entry, +1 per accepted write, saturates at 2^ADDR_WIDTH.
REQ-019 All non-LOAD states: im_addr_o=if_addr_i, im_wr_o=0, load_ready_o=0; im_rd_o=1 only in RUN with stallPC_o=0.
REQ-020 RUN, priority stop > load_use_i > branch/jump: stop -> DRAIN next cycle, drain counter loaded DRAIN_CYCLES-1.
REQ-021 RUN load_use_i (no stop): stallPC_o=stallIF_ID_o=flushID_EX_o=1 same cycle (combinational); flushIF_ID_o=0 even if branch_taken_i/jump_i set.
REQ-022 RUN branch_taken_i or jump_i (no load_use_i, no stop): flushIF_ID_o=1 same cycle.
REQ-023 DRAIN: stallPC_o=1, flushIF_ID_o=1, hazard inputs ignored; counter decrements each cycle; at 0 -> HALT next cycle (exactly DRAIN_CYCLES cycles in DRAIN).
REQ-024 IDLE, LOAD, HALT: stallPC_o=1, all other control outputs 0.
REQ-025 stall_cnt_o +1 per RUN cycle with load_use_i asserted and stop low; saturates at 16'hFFFF; cleared only by rst.
REQ-026 HALT -> RUN resumes at held if_addr_i; start and stop asserted together in RUN: stop wins.

Reset
REQ-027 rst in any state, including mid-LOAD or mid-DRAIN: next state IDLE, drain counter 0, load_cnt_o 0, stall_cnt_o 0.
REQ-028 Post-reset outputs: run_o=0, load_ready_o=0, im_rd_o=0, im_wr_o=0, stallPC_o=1, other controls 0; rst overrides start/load_valid_i that cycle.

Structure
REQ-029 Shared package holds state encoding constants, DRAIN_CYCLES default, and the width constants.
REQ-030 One sub-module, sat_counter (parameterized width, clear, enable, saturate), instantiated for load_cnt_o and stall_cnt_o.
REQ-031 State register, drain counter, and status counters registered; all control outputs combinational from state and inputs.

Verification
REQ-032 Load 3 words at addresses 0x00..0x02 with last on the third -> 3 im_wr_o pulses at those addresses/data, load_cnt_o=3, state returns to IDLE.
REQ-033 start from IDLE, then stop in RUN -> exactly 4 DRAIN cycles with stallPC_o=flushIF_ID_o=1, then HALT, run_o=0.
REQ-034 RUN with load_use_i and branch_taken_i both high for 1 cycle -> stallPC_o=stallIF_ID_o=flushID_EX_o=1, flushIF_ID_o=0, stall_cnt_o +1.
REQ-035 rst on the 2nd write of a LOAD burst -> IDLE next cycle, load_cnt_o=0, no im_wr_o after the reset cycle.
REQ-036 load_use_i held 70000 RUN cycles -> stall_cnt_o saturates at 16'hFFFF.
REQ-037 HALT with load_valid_i and start both high -> LOAD entered, start ignored.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Fetch sequencer shared definitions.
// State encoding, default widths and drain length.
package fetch_seq_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 8;
  localparam int DRAIN_DEF   = 4;
  localparam int STALL_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and enable.
// Ports: clk, rst, clr, en in; cnt out (holds at MAX).
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && cnt != MAX)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: program load, run, drain, halt.
// Ports: start/stop, load stream, IM port, hazard ctrl, status.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W_DEF,
  parameter int ADDR_WIDTH   = ADDR_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load_valid_i,
  input  logic                  load_last_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  load_ready_o,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [ADDR_WIDTH-1:0] im_addr_o,
  output logic                  im_rd_o,
  output logic                  im_wr_o,
  output logic [DATA_WIDTH-1:0] im_wdata_o,
  input  logic                  load_use_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
  output logic                  stallPC_o,
  output logic                  stallIF_ID_o,
  output logic                  flushIF_ID_o,
  output logic                  flushID_EX_o,
  output logic                  run_o,
  output logic [2:0]            state_o,
  output logic [ADDR_WIDTH:0]   load_cnt_o,
  output logic [STALL_W-1:0]    stall_cnt_o
);

  localparam int CW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LD =
    CW'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] LOAD_MAX =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] drain_q;

  logic in_load;
  logic in_run;
  logic in_drain;
  logic accept;
  logic hz_stall;
  logic hz_flush;
  logic load_enter;
  logic stall_inc;

  assign in_load  = (state_q == S_LOAD);
  assign in_run   = (state_q == S_RUN);
  assign in_drain = (state_q == S_DRAIN);

  // stop closes the loader port so no write
  // lands on the cycle LOAD is abandoned
  assign load_ready_o = in_load && !stop;
  assign accept       = load_valid_i && load_ready_o;

  // stop outranks hazards; load-use outranks redirect
  assign hz_stall = in_run && !stop && load_use_i;
  assign hz_flush = in_run && !stop && !load_use_i
                    && (branch_taken_i || jump_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (load_valid_i)
          state_d = S_LOAD;
        else if (start)
          state_d = S_RUN;
      end
      S_LOAD: begin
        if (stop)
          state_d = S_IDLE;
        else if (accept && load_last_i)
          state_d = S_IDLE;
      end
      S_RUN: begin
        if (stop)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == '0)
          state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_run && stop)
        drain_q <= DRAIN_LD;
      else if (in_drain && drain_q != '0)
        drain_q <= drain_q - CW'(1);
    end
  end

  assign stallPC_o    = !in_run || hz_stall;
  assign stallIF_ID_o = hz_stall;
  assign flushID_EX_o = hz_stall;
  assign flushIF_ID_o = in_drain || hz_flush;

  assign im_addr_o  = in_load ? load_addr_i : if_addr_i;
  assign im_wdata_o = in_load ? load_data_i : '0;
  assign im_wr_o    = accept;
  assign im_rd_o    = in_run && !stallPC_o;

  assign run_o   = in_run;
  assign state_o = state_q;

  assign load_enter = !in_load && (state_d == S_LOAD);
  assign stall_inc  = hz_stall;

  sat_counter #(
    .W   (ADDR_WIDTH + 1),
    .MAX (LOAD_MAX)
  ) u_load_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load_enter),
    .en  (accept),
    .cnt (load_cnt_o)
  );

  sat_counter #(
    .W   (STALL_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (stall_inc),
    .cnt (stall_cnt_o)
  );

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq.
// Hand-computed expectations, single checker task.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        load_valid_i;
  logic        load_last_i;
  logic [7:0]  load_addr_i;
  logic [15:0] load_data_i;
  logic        load_ready_o;
  logic [7:0]  if_addr_i;
  logic [7:0]  im_addr_o;
  logic        im_rd_o;
  logic        im_wr_o;
  logic [15:0] im_wdata_o;
  logic        load_use_i;
  logic        branch_taken_i;
  logic        jump_i;
  logic        stallPC_o;
  logic        stallIF_ID_o;
  logic        flushIF_ID_o;
  logic        flushID_EX_o;
  logic        run_o;
  logic [2:0]  state_o;
  logic [8:0]  load_cnt_o;
  logic [15:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_drain;
  logic [15:0] wdat [3];

  always #5 clk = ~clk;

  fetch_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .load_valid_i   (load_valid_i),
    .load_last_i    (load_last_i),
    .load_addr_i    (load_addr_i),
    .load_data_i    (load_data_i),
    .load_ready_o   (load_ready_o),
    .if_addr_i      (if_addr_i),
    .im_addr_o      (im_addr_o),
    .im_rd_o        (im_rd_o),
    .im_wr_o        (im_wr_o),
    .im_wdata_o     (im_wdata_o),
    .load_use_i     (load_use_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .stallPC_o      (stallPC_o),
    .stallIF_ID_o   (stallIF_ID_o),
    .flushIF_ID_o   (flushIF_ID_o),
    .flushID_EX_o   (flushID_EX_o),
    .run_o          (run_o),
    .state_o        (state_o),
    .load_cnt_o     (load_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    wdat[0] = 16'h1234;
    wdat[1] = 16'hBEEF;
    wdat[2] = 16'h0F0F;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    load_valid_i = 1'b0;
    load_last_i = 1'b0;
    load_addr_i = '0;
    load_data_i = '0;
    if_addr_i = '0;
    load_use_i = 1'b0;
    branch_taken_i = 1'b0;
    jump_i = 1'b0;
    cyc;
    cyc;
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_run", 32'(run_o), 32'd0);
    chk("rst_ready", 32'(load_ready_o), 32'd0);
    chk("rst_rd", 32'(im_rd_o), 32'd0);
    chk("rst_wr", 32'(im_wr_o), 32'd0);
    chk("rst_stallpc", 32'(stallPC_o), 32'd1);
    chk("rst_stallifid", 32'(stallIF_ID_o), 32'd0);
    chk("rst_flushifid", 32'(flushIF_ID_o), 32'd0);
    chk("rst_flushidex", 32'(flushID_EX_o), 32'd0);
    chk("rst_lcnt", 32'(load_cnt_o), 32'd0);
    chk("rst_scnt", 32'(stall_cnt_o), 32'd0);

    // program load: 3 words, last on third
    load_valid_i = 1'b1;
    chk("idle_no_wr", 32'(im_wr_o), 32'd0);
    cyc;
    for (int i = 0; i < 3; i++) begin
      load_addr_i = 8'(i);
      load_data_i = wdat[i];
      load_last_i = (i == 2);
      #1;
      chk("ld_state", 32'(state_o), 32'd1);
      chk("ld_ready", 32'(load_ready_o), 32'd1);
      chk("ld_wr", 32'(im_wr_o), 32'd1);
      chk("ld_rd", 32'(im_rd_o), 32'd0);
      chk("ld_addr", 32'(im_addr_o), i);
      chk("ld_data", 32'(im_wdata_o), 32'(wdat[i]));
      chk("ld_cnt_run", 32'(load_cnt_o), i);
      chk("ld_stallpc", 32'(stallPC_o), 32'd1);
      cyc;
    end
    load_valid_i = 1'b0;
    load_last_i = 1'b0;
    #1;
    chk("ld_done_state", 32'(state_o), 32'd0);
    chk("ld_done_cnt", 32'(load_cnt_o), 32'd3);
    chk("ld_done_wr", 32'(im_wr_o), 32'd0);

    // start from IDLE
    if_addr_i = 8'h10;
    start = 1'b1;
    cyc;
    start = 1'b0;
    #1;
    chk("run_state", 32'(state_o), 32'd2);
    chk("run_run", 32'(run_o), 32'd1);
    chk("run_rd", 32'(im_rd_o), 32'd1);
    chk("run_addr", 32'(im_addr_o), 32'h10);
    chk("run_stallpc", 32'(stallPC_o), 32'd0);

    // load-use beats branch
    load_use_i = 1'b1;
    branch_taken_i = 1'b1;
    #1;
    chk("lu_stallpc", 32'(stallPC_o), 32'd1);
    chk("lu_stallifid", 32'(stallIF_ID_o), 32'd1);
    chk("lu_flushidex", 32'(flushID_EX_o), 32'd1);
    chk("lu_flushifid", 32'(flushIF_ID_o), 32'd0);
    chk("lu_rd", 32'(im_rd_o), 32'd0);
    cyc;
    load_use_i = 1'b0;
    branch_taken_i = 1'b0;
    #1;
    chk("lu_scnt", 32'(stall_cnt_o), 32'd1);
    chk("lu_clear_flush", 32'(flushIF_ID_o), 32'd0);

    jump_i = 1'b1;
    #1;
    chk("jmp_flushifid", 32'(flushIF_ID_o), 32'd1);
    chk("jmp_stallpc", 32'(stallPC_o), 32'd0);
    jump_i = 1'b0;

    // start+stop together: stop wins
    stop = 1'b1;
    start = 1'b1;
    cyc;
    stop = 1'b0;
    start = 1'b0;
    load_use_i = 1'b1;
    #1;
    chk("drn_state", 32'(state_o), 32'd3);
    n_drain = 0;
    while (state_o == 3'd3 && n_drain < 10) begin
      chk("drn_stallpc", 32'(stallPC_o), 32'd1);
      chk("drn_flushifid", 32'(flushIF_ID_o), 32'd1);
      chk("drn_stallifid", 32'(stallIF_ID_o), 32'd0);
      n_drain++;
      cyc;
    end
    load_use_i = 1'b0;
    #1;
    chk("drn_len", n_drain, 32'd4);
    chk("halt_state", 32'(state_o), 32'd4);
    chk("halt_run", 32'(run_o), 32'd0);
    chk("halt_scnt", 32'(stall_cnt_o), 32'd1);

    // HALT: load_valid beats start
    load_valid_i = 1'b1;
    start = 1'b1;
    load_addr_i = 8'h05;
    load_data_i = 16'h5555;
    cyc;
    start = 1'b0;
    #1;
    chk("hl_state", 32'(state_o), 32'd1);
    chk("hl_cnt_clr", 32'(load_cnt_o), 32'd0);
    cyc;
    chk("hl_cnt1", 32'(load_cnt_o), 32'd1);

    // reset on second write
    load_addr_i = 8'h06;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    #1;
    chk("rl_state", 32'(state_o), 32'd0);
    chk("rl_lcnt", 32'(load_cnt_o), 32'd0);
    chk("rl_scnt", 32'(stall_cnt_o), 32'd0);
    chk("rl_wr", 32'(im_wr_o), 32'd0);
    cyc;
    stop = 1'b1;
    #1;
    chk("ls_state", 32'(state_o), 32'd1);
    chk("ls_wr", 32'(im_wr_o), 32'd0);
    cyc;
    stop = 1'b0;
    load_valid_i = 1'b0;
    #1;
    chk("ls_idle", 32'(state_o), 32'd0);
    chk("ls_cnt", 32'(load_cnt_o), 32'd0);

    // stall counter saturation
    start = 1'b1;
    cyc;
    start = 1'b0;
    load_use_i = 1'b1;
    repeat (70000) cyc;
    chk("sat_scnt", 32'(stall_cnt_o), 32'hFFFF);
    load_use_i = 1'b0;
    cyc;
    chk("sat_hold", 32'(stall_cnt_o), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
